// File: rtl/run_detect_sched.sv
// run_detect_sched: one run-length detector shared by NUM_CH serial bit streams.
// Each cycle a round-robin arbiter grants one requesting channel. The granted
// channel's saved context {last_bit, run_cnt} is restored, updated with the new
// bit and written back. A run of RUN_LEN equal bits produces a registered hit.
// Reset is asynchronous and active-low on the port named 'reset'.
module run_detect_sched #(
    parameter int NUM_CH  = 4,
    parameter int RUN_LEN = 3,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH-1:0]         in_bit,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH-1:0]         ch_clr,
    output logic                      hit_valid,
    output logic [$clog2(NUM_CH)-1:0] hit_ch,
    output logic                      hit_bit,
    output logic [CNT_W-1:0]          hit_total
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_MAX = RC_W'(RUN_LEN);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Per-channel contexts, arbiter pointer and registered hit outputs
    logic [CH_W-1:0]   r_rrPtr;
    logic [RC_W-1:0]   r_runCnt [NUM_CH];
    logic [NUM_CH-1:0] r_lastBit;
    logic              r_hitValid;
    logic [CH_W-1:0]   r_hitCh;
    logic              r_hitBit;
    logic [CNT_W-1:0]  r_hitTotal;

    // Arbiter and datapath intermediates
    logic [CH_W-1:0]   w_scanIdx;
    logic [CH_W-1:0]   w_grantIdx;
    logic              w_found;
    logic [NUM_CH-1:0] w_grant;
    logic              w_accept;
    logic              w_curBit;
    logic [RC_W-1:0]   w_ctxCnt;
    logic              w_ctxLast;
    logic [RC_W-1:0]   w_newCnt;
    logic [RC_W-1:0]   w_storeCnt;
    logic              w_hit;

    // Channel index reached k steps after base, wrapping at NUM_CH
    function automatic logic [CH_W-1:0] wrapIdx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // Round-robin search for the first requester starting at the pointer
    always_comb begin
        w_scanIdx  = '0;
        w_grantIdx = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scanIdx = wrapIdx(int'(r_rrPtr), k);
            if (!w_found && in_valid[w_scanIdx]) begin
                w_found    = 1'b1;
                w_grantIdx = w_scanIdx;
            end
        end
        w_grant = w_found ? (NUM_CH'(1) << w_grantIdx) : '0;
    end

    assign w_accept = reset && en && w_found;
    assign in_ready = (reset && en) ? w_grant : '0;

    // Restore the granted context (a same-cycle clear wins) and extend the run
    always_comb begin
        w_curBit  = in_bit[w_grantIdx];
        w_ctxCnt  = ch_clr[w_grantIdx] ? '0 : r_runCnt[w_grantIdx];
        w_ctxLast = ch_clr[w_grantIdx] ? 1'b0 : r_lastBit[w_grantIdx];
        if ((w_ctxCnt == '0) || (w_curBit != w_ctxLast)) begin
            w_newCnt = RC_W'(1);
        end else if (w_ctxCnt == RUN_MAX) begin
            w_newCnt = RUN_MAX;
        end else begin
            w_newCnt = w_ctxCnt + RC_W'(1);
        end
        w_hit      = w_accept && (w_newCnt == RUN_MAX);
        w_storeCnt = (w_hit && (OVERLAP == 0)) ? '0 : w_newCnt;
    end

    // Write back the granted context and apply clears to the other channels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_runCnt[i] <= '0;
            r_lastBit <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept && (w_grantIdx == CH_W'(i))) begin
                    r_runCnt[i]  <= w_storeCnt;
                    r_lastBit[i] <= w_curBit;
                end else if (ch_clr[i]) begin
                    r_runCnt[i]  <= '0;
                    r_lastBit[i] <= 1'b0;
                end
            end
        end
    end

    // Advance the round-robin pointer past the channel just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr <= '0;
        end else if (w_accept) begin
            r_rrPtr <= (w_grantIdx == LAST_CH) ? '0 : w_grantIdx + CH_W'(1);
        end
    end

    // Register the hit pulse, its channel/value and the running hit count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hitValid <= 1'b0;
            r_hitCh    <= '0;
            r_hitBit   <= 1'b0;
            r_hitTotal <= '0;
        end else begin
            r_hitValid <= w_hit;
            if (w_hit) begin
                r_hitCh    <= w_grantIdx;
                r_hitBit   <= w_curBit;
                r_hitTotal <= r_hitTotal + CNT_W'(1);
            end
        end
    end

    assign hit_valid = r_hitValid;
    assign hit_ch    = r_hitCh;
    assign hit_bit   = r_hitBit;
    assign hit_total = r_hitTotal;

endmodule

// File: tb/tb_run_detect_sched.sv
// tb_run_detect_sched: drives two detector instances (overlapping runs with a
// 16-bit counter, non-overlapping runs with a 4-bit counter so wrap-around is
// reached quickly) with directed sequences and random traffic, and compares
// them against a run-length model kept in plain integers.
module tb_run_detect_sched;

    localparam int NUM_CH  = 4;
    localparam int RUN_LEN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [3:0] inValid = '0;
    logic [3:0] inBit = '0;
    logic [3:0] chClr = '0;

    logic [3:0]  readyA, readyB;
    logic        hitValidA, hitValidB;
    logic [1:0]  hitChA, hitChB;
    logic        hitBitA, hitBitB;
    logic [15:0] totalA;
    logic [3:0]  totalB;

    int compared = 0;
    int mismatched = 0;

    // Reference model: unbounded run lengths per channel for each instance
    int          rrPtr;
    int          runLen [2][NUM_CH];
    bit          lastBit [2][NUM_CH];
    bit          expHitValid [2];
    int          expHitCh [2];
    bit          expHitBit [2];
    int unsigned expTotal [2];
    logic [3:0]  srcBit;

    run_detect_sched dutA (
        .clk(clk), .reset(reset), .en(en), .in_valid(inValid), .in_bit(inBit),
        .in_ready(readyA), .ch_clr(chClr), .hit_valid(hitValidA),
        .hit_ch(hitChA), .hit_bit(hitBitA), .hit_total(totalA)
    );

    run_detect_sched #(.OVERLAP(0), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .en(en), .in_valid(inValid), .in_bit(inBit),
        .in_ready(readyB), .ch_clr(chClr), .hit_valid(hitValidB),
        .hit_ch(hitChB), .hit_bit(hitBitB), .hit_total(totalB)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        rrPtr = 0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                runLen[m][i]  = 0;
                lastBit[m][i] = 1'b0;
            end
            expHitValid[m] = 1'b0;
            expHitCh[m]    = 0;
            expHitBit[m]   = 1'b0;
            expTotal[m]    = 0;
        end
    endtask

    // Channel the arbiter should grant now, or -1 for none
    function automatic int modelGrant();
        int idx;
        if (!reset || !en) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (rrPtr + k) % NUM_CH;
            if (inValid[idx]) return idx;
        end
        return -1;
    endfunction

    // Effect of one clock edge given grant g
    task automatic modelEdge(input int g);
        bit b;
        bit hit;
        for (int m = 0; m < 2; m++) begin
            expHitValid[m] = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (chClr[i]) begin
                    runLen[m][i]  = 0;
                    lastBit[m][i] = 1'b0;
                end
            end
            if (g >= 0) begin
                b = inBit[g];
                if (runLen[m][g] == 0 || b != lastBit[m][g]) runLen[m][g] = 1;
                else runLen[m][g] = runLen[m][g] + 1;
                lastBit[m][g] = b;
                hit = (m == 0) ? (runLen[m][g] >= RUN_LEN) : (runLen[m][g] == RUN_LEN);
                if (hit) begin
                    if (m == 1) runLen[m][g] = 0;
                    expHitValid[m] = 1'b1;
                    expHitCh[m]    = g;
                    expHitBit[m]   = b;
                    expTotal[m]    = expTotal[m] + 1;
                end
            end
        end
        if (g >= 0) rrPtr = (g + 1) % NUM_CH;
    endtask

    task automatic checkReady(input int g);
        logic [3:0] expReady;
        expReady = (g < 0) ? 4'b0000 : 4'(1 << g);
        checkOutput("in_ready A", 32'(readyA), 32'(expReady));
        checkOutput("in_ready B", 32'(readyB), 32'(expReady));
    endtask

    task automatic checkHits();
        checkOutput("hit_valid A", 32'(hitValidA), 32'(expHitValid[0]));
        checkOutput("hit_ch A",    32'(hitChA),    32'(expHitCh[0]));
        checkOutput("hit_bit A",   32'(hitBitA),   32'(expHitBit[0]));
        checkOutput("hit_total A", 32'(totalA),    expTotal[0] % 32'd65536);
        checkOutput("hit_valid B", 32'(hitValidB), 32'(expHitValid[1]));
        checkOutput("hit_ch B",    32'(hitChB),    32'(expHitCh[1]));
        checkOutput("hit_bit B",   32'(hitBitB),   32'(expHitBit[1]));
        checkOutput("hit_total B", 32'(totalB),    expTotal[1] % 32'd16);
    endtask

    // One clock cycle of stimulus, called at a falling edge
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] b,
                                 input logic [3:0] clr, input logic e, output int g);
        inValid = v;
        inBit   = b;
        chClr   = clr;
        en      = e;
        #1;
        g = modelGrant();
        checkReady(g);
        @(posedge clk);
        modelEdge(g);
        #1;
        checkHits();
        @(negedge clk);
    endtask

    // Hold reset low for one cycle with requests pending, called at a falling edge
    task automatic pulseReset();
        inValid = 4'b1111;
        chClr   = '0;
        en      = 1'b1;
        reset   = 1'b0;
        modelReset();
        #1;
        checkReady(-1);
        checkHits();
        @(posedge clk);
        #1;
        checkHits();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int g;
        int pick;
        logic [3:0] v;
        logic [3:0] clr;
        logic e;

        $display("[TB] run_detect_sched bench starting");
        modelReset();
        srcBit = '0;
        @(negedge clk);
        pulseReset();

        // Reset mid-run discards the partial run on channel 0
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        pulseReset();
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        checkOutput("T1 total after reset", 32'(totalA), 32'd0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        checkOutput("T1 total A", 32'(totalA), 32'd1);
        checkOutput("T1 hit_valid A", 32'(hitValidA), 32'd1);

        // Single channel, overlapping vs non-overlapping runs
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        checkOutput("T2 total A after 4", 32'(totalA), 32'd2);
        checkOutput("T2 total B after 4", 32'(totalB), 32'd1);
        for (int i = 0; i < 2; i++) applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, g);
        checkOutput("T2 total A after 6", 32'(totalA), 32'd4);
        checkOutput("T2 total B after 6", 32'(totalB), 32'd2);

        // All channels requesting with alternating bit values
        pulseReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1111, 4'b1010, 4'b0000, 1'b1, g);
            checkOutput("T3 grant order", 32'(g), 32'(i % 4));
        end
        checkOutput("T3 total A", 32'(totalA), 32'd8);
        checkOutput("T3 total B", 32'(totalB), 32'd4);
        checkOutput("T3 last hit_ch A", 32'(hitChA), 32'd3);
        checkOutput("T3 last hit_bit A", 32'(hitBitA), 32'd1);

        // Broken run on channel 2
        pulseReset();
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, g);
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, g);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1, g);
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, g);
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, g);
        checkOutput("T4 no early hit", 32'(totalA), 32'd0);
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b1, g);
        checkOutput("T4 total A", 32'(totalA), 32'd1);
        checkOutput("T4 hit_ch A", 32'(hitChA), 32'd2);

        // Clear colliding with an accept on channel 1
        pulseReset();
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, g);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, g);
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b1, g);
        checkOutput("T5 no hit on clear", 32'(hitValidA), 32'd0);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, g);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, g);
        checkOutput("T5 total A", 32'(totalA), 32'd1);
        checkOutput("T5 total B", 32'(totalB), 32'd1);

        // Freeze with everything requesting, then resume at the saved pointer
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1, g);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0, g);
            checkOutput("T6 frozen ready", 32'(readyA), 32'd0);
        end
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1, g);
        checkOutput("T6 resume grant", 32'(g), 32'd2);

        // Random traffic; the 4-bit counter wraps many times along the way
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulseReset();
            end else begin
                pick = int'($urandom_range(0, 3));
                v = (pick == 0) ? 4'($urandom_range(0, 15)) : 4'b1111 & 4'($urandom_range(1, 15));
                clr = '0;
                for (int i = 0; i < NUM_CH; i++) clr[i] = ($urandom_range(0, 40) == 0);
                e = ($urandom_range(0, 15) != 0);
                applyStimulus(v, srcBit, clr, e, g);
                if (g >= 0 && $urandom_range(0, 3) == 0) srcBit[g] = ~srcBit[g];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
